// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : Memory-access stage plus MEM/WB pipeline register. Performs
//            data-memory loads and stores and resolves JEQ (redirect and
//            upstream flush). It also presents write-back data and forwarding
//            qualifiers to the register file and hazard unit.
// Revision : 1.0  initial release
// ============================================================================
module mem_wb_stage #(
  parameter int AW = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ControlsIn,
  input  logic [15:0] ResultIn,
  input  logic        ZeroIn,
  input  logic [15:0] DataIn,
  input  logic [15:0] MemAddrIn,
  input  logic [15:0] JEQAddrIn,
  input  logic [2:0]  Reg1In,
  output logic        BranchTaken,
  output logic [15:0] BranchTarget,
  output logic        FlushOut,
  output logic        RegWriteOut,
  output logic [2:0]  WriteRegOut,
  output logic [15:0] WriteDataOut,
  output logic        FwdValid,
  output logic        LoadDone
);

  localparam int c_DEPTH = 1 << AW;

  // Control field decode from the EX/MEM register
  logic          w_regWrite;
  logic          w_memToReg;
  logic          w_memRead;
  logic          w_memWrite;
  logic          w_jeq;
  logic [AW-1:0] w_addr;

  assign w_regWrite = ControlsIn[4];
  assign w_memToReg = ControlsIn[3];
  assign w_memRead  = ControlsIn[2];
  assign w_memWrite = ControlsIn[1];
  assign w_jeq      = ControlsIn[0];

  // Upper address bits are dropped, so addresses alias modulo the depth.
  assign w_addr = MemAddrIn[AW-1:0];

  generate
    if (AW < 16) begin : g_aliasBits
      logic w_unusedHi;
      assign w_unusedHi = &{1'b0, MemAddrIn[15:AW]};
    end
  endgenerate

  // Data memory; contents deliberately survive reset
  logic [15:0] r_mem [0:c_DEPTH-1];

  // MEM/WB register fields
  logic        r_regWrite;
  logic        r_memToReg;
  logic [15:0] r_result;
  logic [15:0] r_loadData;
  logic [2:0]  r_writeReg;
  logic        r_loadDone;

  // Branch resolution is purely combinational on the current EX/MEM contents
  assign BranchTaken  = w_jeq & ZeroIn;
  assign BranchTarget = JEQAddrIn;
  assign FlushOut     = BranchTaken;

  // Store port: reset in the same cycle suppresses the write
  always_ff @(posedge Clk) begin
    if (!Reset && w_memWrite) begin
      r_mem[w_addr] <= DataIn;
    end
  end

  // MEM/WB capture; the memory read here sees the pre-write value (read-before-write)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_regWrite <= 1'b0;
      r_memToReg <= 1'b0;
      r_result   <= 16'h0000;
      r_loadData <= 16'h0000;
      r_writeReg <= 3'd0;
      r_loadDone <= 1'b0;
    end else begin
      r_regWrite <= w_regWrite;
      r_memToReg <= w_memToReg;
      r_result   <= ResultIn;
      r_loadData <= w_memRead ? r_mem[w_addr] : 16'h0000;
      r_writeReg <= Reg1In;
      r_loadDone <= w_memRead;
    end
  end

  // Write-back selection from registered fields
  assign WriteDataOut = r_memToReg ? r_loadData : r_result;
  assign RegWriteOut  = r_regWrite;
  assign WriteRegOut  = r_writeReg;
  assign FwdValid     = r_regWrite;
  assign LoadDone     = r_loadDone;

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register; sits directly downstream of the EX/MEM register.
- Consumes that register's controls, ALU result, zero flag, store data, memory address, JEQ target and destination register.
- Performs data-memory loads and stores, resolves JEQ (taken-branch redirect and upstream flush), and presents write-back data and forwarding info to the register file and hazard logic.

Parameters:
- AW, 8, data-memory address width; depth = 2^AW words of 16 bits.

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- ControlsIn  in  5  [4] RegWrite, [3] MemToReg, [2] MemRead, [1] MemWrite, [0] Jeq
- ResultIn  in  16  ALU result
- ZeroIn  in  1  ALU zero flag
- DataIn  in  16  store data
- MemAddrIn  in  16  data address; only [AW-1:0] used
- JEQAddrIn  in  16  branch target
- Reg1In  in  3  destination register
- BranchTaken  out  1  Jeq & ZeroIn (combinational)
- BranchTarget  out  16  = JEQAddrIn (combinational)
- FlushOut  out  1  = BranchTaken; flushes IF/ID, ID/EX, EX/MEM
- RegWriteOut  out  1  registered RegWrite
- WriteRegOut  out  3  registered destination register
- WriteDataOut  out  16  write-back value (MemToReg ? load data : ALU result)
- FwdValid  out  1  = RegWriteOut (forwarding qualifier)
- LoadDone  out  1  registered; high for one cycle after a load is captured

Behaviour:
- Reset: Clk, synchronous, active-high; Reset is decided.
- Reset clears the MEM/WB register, so RegWriteOut=0, WriteRegOut=0, WriteDataOut=0 and LoadDone=0 from the edge after Reset is sampled high.
- Memory contents are not affected by reset; the bench initialises memory with stores.
- Memory: 2^AW x 16 array. Address a = MemAddrIn[AW-1:0]; bits [15:AW] are ignored, so addresses alias modulo 2^AW.
- Store: if MemWrite=1 and Reset=0, mem[a] <= DataIn at the rising edge. Stores complete in 0 extra cycles.
- Load: if MemRead=1, the read is synchronous and captured into the MEM/WB register at the same edge.
  - Read-before-write: the captured value is mem[a] from before any write at that edge.
  - With MemRead and MemWrite both 1, the old value is loaded and the new value is stored.
- MEM/WB register, updated every edge when Reset=0, captures RegWrite, MemToReg, ResultIn, load data, Reg1In, and LoadDone <= MemRead.
  - Load data is captured as 0 when MemRead=0.
- WriteDataOut is combinational from registered fields: MemToReg_q ? LoadData_q : Result_q.
- Latency: EX/MEM input to write-back outputs is 1 cycle.
- Branch:
  - BranchTaken, BranchTarget and FlushOut are combinational from the current inputs.
  - This block does not suppress the JEQ instruction's own MEM/WB capture; JEQ carries RegWrite=0, MemWrite=0.
- Reg1In=0 with RegWrite=1 is passed through unchanged; the register file decides whether r0 is writable.
- Undefined control combinations (e.g. Jeq with MemWrite) are executed literally; no checking.
- Reset asserted in the same cycle as MemWrite: the store is suppressed and the pipeline register is cleared.

Test Plan:
- Reset high 2 cycles with random inputs -> RegWriteOut=0, WriteRegOut=0, WriteDataOut=0, LoadDone=0; memory unchanged, checked by a subsequent load.
- Store then load: cycle n ControlsIn=5'b00010, MemAddrIn=16'h0012, DataIn=16'hBEEF; cycle n+1 ControlsIn=5'b11100, MemAddrIn=16'h0012, Reg1In=3 -> after edge n+2 WriteDataOut=16'hBEEF, WriteRegOut=3, RegWriteOut=1, LoadDone=1 for exactly one cycle.
- ALU write-back: ControlsIn=5'b10000, ResultIn=16'h1234, Reg1In=5 -> one cycle later WriteDataOut=16'h1234, RegWriteOut=1, LoadDone=0.
- JEQ: ControlsIn=5'b00001, JEQAddrIn=16'h0040, ZeroIn=1 -> same cycle BranchTaken=1, FlushOut=1, BranchTarget=16'h0040; with ZeroIn=0 -> BranchTaken=0, FlushOut=0.
- Aliasing and read-before-write (AW=8): store 16'hAAAA at 16'h0105, then load 16'h0005 -> 16'hAAAA. Then MemRead+MemWrite same cycle at 16'h0005 with DataIn=16'h5555 -> loads 16'hAAAA; next load -> 16'h5555.
- Reset with MemWrite=1, addr 16'h0020, DataIn=16'h7777 -> later load of 16'h0020 returns the prior value, not 16'h7777.
